// File: rtl/rle_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rle_capture_ctrl
//  Purpose  : Capture sequencer for the rle_enc run-length encoder. Shadows
//             the encoder configuration, gates sampler data into the encoder,
//             counts emitted words against a budget and flushes the pending
//             run before the capture closes.
//  Revision : 1.0 - initial release
// ============================================================================
module rle_capture_ctrl #(
   parameter int CNT_W        = 20,
   parameter int DRAIN_CYCLES = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             cfg_wr,
   input  logic             cfg_rle_en,
   input  logic [1:0]       cfg_rle_mode,
   input  logic [3:0]       cfg_groups,
   input  logic [CNT_W-1:0] cfg_limit,
   input  logic             arm_req,
   input  logic             trig,
   input  logic             stop_req,
   input  logic             done_ack,
   input  logic [31:0]      sample_in,
   input  logic             sample_valid,
   input  logic             rle_valid_out,
   output logic             rle_enable,
   output logic             rle_arm,
   output logic [1:0]       rle_mode,
   output logic [3:0]       rle_groups,
   output logic [31:0]      rle_data,
   output logic             rle_valid,
   output logic [CNT_W-1:0] words,
   output logic             busy,
   output logic             done
);

   localparam int               DW          = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DW-1:0]    C_DRAIN_END = DW'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_ONE       = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARMED = 3'd1,
      S_RUN   = 3'd2,
      S_FLUSH = 3'd3,
      S_DRAIN = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t           r_state;
   logic             r_rle_en;
   logic [CNT_W-1:0] r_limit;
   logic [DW-1:0]    r_drain_cnt;

   logic w_cfg_open;
   logic w_arm_go;
   logic w_limit_hit;
   logic w_run_exit;

   // Configuration and arming are only accepted while no capture is in flight.
   assign w_cfg_open  = (r_state == S_IDLE) || (r_state == S_DONE);
   assign w_arm_go    = arm_req && w_cfg_open;
   // One word of the budget is held back for the run flushed out on FLUSH.
   assign w_limit_hit = (r_limit != '0) && (words >= (r_limit - C_ONE));
   assign w_run_exit  = stop_req || w_limit_hit;

   // Shadow configuration registers, writable only between captures.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rle_en   <= 1'b0;
         r_limit    <= '0;
         rle_mode   <= 2'b00;
         rle_groups <= 4'b0000;
      end else if (cfg_wr && w_cfg_open) begin
         r_rle_en   <= cfg_rle_en;
         r_limit    <= cfg_limit;
         rle_mode   <= cfg_rle_mode;
         rle_groups <= cfg_groups;
      end
   end

   // Emitted-word counter: cleared on arm, saturating while a capture is open.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         words <= '0;
      end else if (w_arm_go) begin
         words <= '0;
      end else if (rle_valid_out && !w_cfg_open && (words != '1)) begin
         words <= words + C_ONE;
      end
   end

   // Capture sequencer with registered encoder controls and status outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_drain_cnt <= '0;
         rle_enable  <= 1'b0;
         rle_arm     <= 1'b0;
         rle_data    <= '0;
         rle_valid   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         rle_valid  <= 1'b0;
         rle_enable <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (arm_req) begin
                  r_state <= S_ARMED;
                  rle_arm <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            S_ARMED: begin
               if (stop_req) begin
                  r_state <= S_DONE;
                  rle_arm <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end else if (trig) begin
                  r_state    <= S_RUN;
                  rle_enable <= r_rle_en;
               end
            end
            S_RUN: begin
               if (w_run_exit) begin
                  r_state <= S_FLUSH;
               end else begin
                  rle_enable <= r_rle_en;
                  rle_data   <= sample_in;
                  rle_valid  <= sample_valid;
               end
            end
            S_FLUSH: begin
               r_state     <= S_DRAIN;
               r_drain_cnt <= '0;
            end
            S_DRAIN: begin
               if (r_drain_cnt == C_DRAIN_END) begin
                  r_state <= S_DONE;
                  rle_arm <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  r_drain_cnt <= r_drain_cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (arm_req) begin
                  r_state <= S_ARMED;
                  rle_arm <= 1'b1;
                  busy    <= 1'b1;
                  done    <= 1'b0;
               end else if (done_ack) begin
                  r_state <= S_IDLE;
                  done    <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               rle_arm <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rle_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rle_capture_ctrl
//  Purpose  : Self-checking bench for rle_capture_ctrl (scoreboarded data path,
//             limit handling, abort, config shadowing, reset, saturation).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rle_capture_ctrl;

   localparam int CNT_W = 10;
   localparam int DRAIN = 4;

   logic             clock = 1'b0;
   logic             reset_n;
   logic             cfg_wr, cfg_rle_en;
   logic [1:0]       cfg_rle_mode;
   logic [3:0]       cfg_groups;
   logic [CNT_W-1:0] cfg_limit;
   logic             arm_req, trig, stop_req, done_ack;
   logic [31:0]      sample_in;
   logic             sample_valid;
   logic             rle_valid_out;
   logic             rle_enable, rle_arm;
   logic [1:0]       rle_mode;
   logic [3:0]       rle_groups;
   logic [31:0]      rle_data;
   logic             rle_valid;
   logic [CNT_W-1:0] words;
   logic             busy, done;

   logic             loopback, force_out, sb_on;
   int               n_checks = 0;
   int               n_fail   = 0;
   int               vcount   = 0;
   logic [31:0]      sb_q[$];

   // Encoder stand-in: either echoes every forwarded sample or is driven directly.
   assign rle_valid_out = loopback ? rle_valid : force_out;

   rle_capture_ctrl #(.CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN)) dut (
      .clock(clock), .reset_n(reset_n),
      .cfg_wr(cfg_wr), .cfg_rle_en(cfg_rle_en), .cfg_rle_mode(cfg_rle_mode),
      .cfg_groups(cfg_groups), .cfg_limit(cfg_limit),
      .arm_req(arm_req), .trig(trig), .stop_req(stop_req), .done_ack(done_ack),
      .sample_in(sample_in), .sample_valid(sample_valid), .rle_valid_out(rle_valid_out),
      .rle_enable(rle_enable), .rle_arm(rle_arm), .rle_mode(rle_mode),
      .rle_groups(rle_groups), .rle_data(rle_data), .rle_valid(rle_valid),
      .words(words), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Forwarded-sample monitor: pops the scoreboard on every rle_valid.
   always @(negedge clock) begin
      if (reset_n && rle_valid) begin
         vcount++;
         if (sb_on) begin
            if (sb_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
            else                  check("rle_data", rle_data, sb_q.pop_front());
         end
      end
   end

   task automatic write_cfg(input logic en, input logic [1:0] mode,
                            input logic [3:0] grp, input logic [CNT_W-1:0] lim);
      cfg_rle_en = en; cfg_rle_mode = mode; cfg_groups = grp; cfg_limit = lim;
      cfg_wr = 1'b1;
      @(negedge clock);
      cfg_wr = 1'b0;
   endtask

   task automatic pulse_arm();
      arm_req = 1'b1; @(negedge clock); arm_req = 1'b0;
   endtask

   task automatic pulse_trig();
      trig = 1'b1; @(negedge clock); trig = 1'b0;
   endtask

   task automatic wait_done(input int max_cycles);
      int n = 0;
      while (!done && n < max_cycles) begin
         @(negedge clock);
         n++;
      end
      check("done_timeout", {31'd0, done}, 32'd1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit hit;
      reset_n = 1'b0; cfg_wr = 0; cfg_rle_en = 0; cfg_rle_mode = 0; cfg_groups = 0;
      cfg_limit = 0; arm_req = 0; trig = 0; stop_req = 0; done_ack = 0;
      sample_in = 0; sample_valid = 0; loopback = 0; force_out = 0; sb_on = 0;
      repeat (3) @(negedge clock);
      check("rst_ctrl", {27'd0, rle_valid, rle_enable, rle_arm, busy, done}, 32'd0);
      check("rst_words", 32'(words), 32'd0);
      check("rst_shadow", {26'd0, rle_mode, rle_groups}, 32'd0);
      reset_n = 1'b1;
      @(negedge clock);

      // Raw pass-through capture, scoreboarded data, with a config write mid-run.
      write_cfg(1'b0, 2'b01, 4'b0000, '0);
      loopback = 1'b1;
      pulse_arm();
      check("armed_busy_arm", {30'd0, busy, rle_arm}, 32'd3);
      pulse_trig();
      check("run_enable_raw", {31'd0, rle_enable}, 32'd0);
      sb_on = 1'b1; vcount = 0;
      for (int i = 0; i < 100; i++) begin
         sample_in = $urandom; sample_valid = 1'b1;
         cfg_wr = (i == 10); cfg_rle_mode = 2'b11;
         sb_q.push_back(sample_in);
         @(negedge clock);
      end
      cfg_wr = 1'b0; sample_valid = 1'b0;
      stop_req = 1'b1; @(negedge clock); stop_req = 1'b0;
      check("flush_outputs", {29'd0, rle_valid, rle_enable, busy}, 32'd1);
      repeat (DRAIN) @(negedge clock);
      check("done_early", {31'd0, done}, 32'd0);
      @(negedge clock);
      check("done_after_drain", {31'd0, done}, 32'd1);
      check("t1_vcount", vcount, 32'd100);
      check("t1_sb_empty", sb_q.size(), 32'd0);
      check("t1_words", 32'(words), 32'd100);
      check("mode_held_in_run", {30'd0, rle_mode}, 32'd1);
      sb_on = 1'b0; loopback = 1'b0;
      write_cfg(1'b0, 2'b10, 4'b0000, '0);
      check("mode_upd_in_done", {30'd0, rle_mode}, 32'd2);
      done_ack = 1'b1; @(negedge clock); done_ack = 1'b0;
      check("idle_after_ack", {30'd0, busy, done}, 32'd0);

      // Word budget of 8: FLUSH once 7 words are out, pending run makes 8.
      write_cfg(1'b1, 2'b00, 4'b1110, CNT_W'(8));
      check("groups_shadow", {28'd0, rle_groups}, 32'hE);
      pulse_arm();
      check("t2_words_clr", 32'(words), 32'd0);
      pulse_trig();
      check("run_enable_rle", {31'd0, rle_enable}, 32'd1);
      hit = 1'b0;
      for (int k = 0; k < 20 && !hit; k++) begin
         sample_in = 32'hA5A5_A5A5; sample_valid = 1'b1;
         force_out = (k % 2 == 1);
         @(negedge clock);
         if (words == CNT_W'(7)) hit = 1'b1;
      end
      force_out = 1'b0;
      check("t2_limit_reached", {31'd0, hit}, 32'd1);
      check("t2_still_run", {31'd0, rle_enable}, 32'd1);
      @(negedge clock);
      check("t2_flush_entered", {30'd0, rle_enable, rle_valid}, 32'd0);
      check("t2_words_at_flush", 32'(words), 32'd7);
      sample_valid = 1'b0; force_out = 1'b1;
      @(negedge clock);
      force_out = 1'b0;
      wait_done(20);
      check("t2_words_done", 32'(words), 32'd8);

      // Re-arm straight from DONE clears the counter.
      pulse_arm();
      check("rearm_status", {29'd0, rle_arm, busy, done}, 32'd6);
      check("rearm_words", 32'(words), 32'd0);

      // Abort: stop_req and trig together in ARMED.
      vcount = 0;
      stop_req = 1'b1; trig = 1'b1; @(negedge clock); stop_req = 1'b0; trig = 1'b0;
      check("abort_status", {29'd0, rle_arm, busy, done}, 32'd1);
      check("abort_no_valid", vcount, 32'd0);
      check("abort_words", 32'(words), 32'd0);
      done_ack = 1'b1; @(negedge clock); done_ack = 1'b0;

      // Asynchronous reset in the middle of a run.
      write_cfg(1'b1, 2'b10, 4'b0101, '0);
      loopback = 1'b1;
      pulse_arm();
      pulse_trig();
      for (int i = 0; i < 5; i++) begin
         sample_in = 32'h1000 + i; sample_valid = 1'b1;
         @(negedge clock);
      end
      @(posedge clock);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_ctrl", {27'd0, rle_valid, rle_enable, rle_arm, busy, done}, 32'd0);
      check("async_rst_words", 32'(words), 32'd0);
      check("async_rst_data", rle_data, 32'd0);
      check("async_rst_shadow", {26'd0, rle_mode, rle_groups}, 32'd0);
      sample_valid = 1'b0; loopback = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      pulse_trig();
      check("trig_ignored_idle", {30'd0, busy, done}, 32'd0);

      // Budget of one word: RUN lasts one cycle and forwards nothing.
      write_cfg(1'b1, 2'b00, 4'b0000, CNT_W'(1));
      vcount = 0;
      pulse_arm();
      pulse_trig();
      sample_in = 32'hDEAD_BEEF; sample_valid = 1'b1;
      wait_done(20);
      sample_valid = 1'b0;
      check("lim1_no_valid", vcount, 32'd0);

      // Maximum budget with the encoder emitting every cycle: counter saturates.
      write_cfg(1'b1, 2'b00, 4'b0000, '1);
      force_out = 1'b1;
      pulse_arm();
      pulse_trig();
      wait_done(2000);
      check("sat_words", 32'(words), 32'h3FF);
      repeat (3) @(negedge clock);
      check("sat_no_wrap", 32'(words), 32'h3FF);
      force_out = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
